// File: rtl/uart_tx_drain.sv
// Drains a first-word-fall-through byte FIFO onto an 8N1 serial line.
// A waiting byte is popped on the final stop-bit cycle, so consecutive frames have no idle gap.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] LAST_TICK = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [15:0] bit_timer;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        bit_done;

  assign bit_done = (bit_timer == LAST_TICK);

  // A byte is only taken when a frame can begin immediately: from IDLE or on the last stop cycle.
  assign fifo_rd = !rst && !fifo_empty &&
                   ((state == IDLE) || ((state == STOP) && bit_done));

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      bit_timer <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bit_timer <= '0;
          tx        <= 1'b1;
          if (fifo_rd) begin
            shift <= fifo_rdata;
            tx    <= 1'b0;
            state <= START;
          end
        end

        START: begin
          if (bit_done) begin
            bit_timer <= '0;
            bit_cnt   <= '0;
            tx        <= shift[0];
            state     <= DATA;
          end else begin
            bit_timer <= bit_timer + 16'd1;
          end
        end

        // tx is loaded one bit ahead so the line value comes straight from a flop.
        DATA: begin
          if (bit_done) begin
            bit_timer <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            bit_timer <= bit_timer + 16'd1;
          end
        end

        STOP: begin
          if (bit_done) begin
            bit_timer <= '0;
            if (fifo_rd) begin
              shift <= fifo_rdata;
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            bit_timer <= bit_timer + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: directed frame checks at CLKS_PER_BIT=4 and a random
// push/decode scoreboard on instances with CLKS_PER_BIT=2 and 7.
module tb_uart_tx_drain;

  localparam int CPB4 = 4;
  localparam int NRAND = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       empty4 = 1'b1, empty2 = 1'b1, empty7 = 1'b1;
  logic [7:0] rdata4 = 8'h00, rdata2 = 8'h00, rdata7 = 8'h00;
  logic       rd4, rd2, rd7;
  logic       tx4, tx2, tx7;
  logic       busy4, busy2, busy7;

  uart_tx_drain #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .fifo_empty(empty4), .fifo_rdata(rdata4),
    .fifo_rd(rd4), .tx(tx4), .busy(busy4)
  );
  uart_tx_drain #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_rdata(rdata2),
    .fifo_rd(rd2), .tx(tx2), .busy(busy2)
  );
  uart_tx_drain #(.CLKS_PER_BIT(7)) dut7 (
    .clk(clk), .rst(rst), .fifo_empty(empty7), .fifo_rdata(rdata7),
    .fifo_rd(rd7), .tx(tx7), .busy(busy7)
  );

  // FIFO models: a push request is accepted at the next rising edge, a pop removes the head.
  logic [7:0] q4[$], q2[$], q7[$];
  logic       push_v4, push_vr;
  logic [7:0] push_d4, push_dr;

  always @(posedge clk) begin
    if (rd4 && q4.size() > 0) void'(q4.pop_front());
    if (push_v4) q4.push_back(push_d4);
    empty4 <= (q4.size() == 0);
    rdata4 <= (q4.size() == 0) ? 8'h00 : q4[0];
  end

  always @(posedge clk) begin
    if (rd2 && q2.size() > 0) void'(q2.pop_front());
    if (push_vr) q2.push_back(push_dr);
    empty2 <= (q2.size() == 0);
    rdata2 <= (q2.size() == 0) ? 8'h00 : q2[0];
  end

  always @(posedge clk) begin
    if (rd7 && q7.size() > 0) void'(q7.pop_front());
    if (push_vr) q7.push_back(push_dr);
    empty7 <= (q7.size() == 0);
    rdata7 <= (q7.size() == 0) ? 8'h00 : q7[0];
  end

  // Popping an empty FIFO or popping during reset is tallied for a final check.
  int viol = 0;
  always @(negedge clk) begin
    if (rd4 && (empty4 || rst)) viol++;
    if (rd2 && (empty2 || rst)) viol++;
    if (rd7 && (empty7 || rst)) viol++;
  end

  // Line receivers: find the start edge, then sample each bit at its centre.
  int         cnt2 = 0, cnt7 = 0, ferr2 = 0, ferr7 = 0;
  bit         rx2 = 1'b0, rx7 = 1'b0;
  logic [7:0] sh2 = 8'h00, sh7 = 8'h00;
  logic [7:0] dec2[$], dec7[$];

  always @(negedge clk) begin
    int idx;
    if (rx2) cnt2++;
    else if (tx2 === 1'b0) begin rx2 = 1'b1; cnt2 = 0; end
    if (rx2 && (cnt2 % 2 == 1)) begin
      idx = cnt2 / 2;
      if (idx == 0 && tx2 !== 1'b0) ferr2++;
      else if (idx >= 1 && idx <= 8) sh2[idx-1] = tx2;
      else if (idx == 9) begin
        if (tx2 !== 1'b1) ferr2++;
        dec2.push_back(sh2);
        rx2 = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int idx;
    if (rx7) cnt7++;
    else if (tx7 === 1'b0) begin rx7 = 1'b1; cnt7 = 0; end
    if (rx7 && (cnt7 % 7 == 3)) begin
      idx = cnt7 / 7;
      if (idx == 0 && tx7 !== 1'b0) ferr7++;
      else if (idx >= 1 && idx <= 8) sh7[idx-1] = tx7;
      else if (idx == 9) begin
        if (tx7 !== 1'b1) ferr7++;
        dec7.push_back(sh7);
        rx7 = 1'b0;
      end
    end
  end

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected line level k cycles into a frame: start, eight data bits LSB first, stop.
  function automatic logic frameBit(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB4;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    push_d4 = b;
    push_v4 = 1'b1;
    @(negedge clk);
    push_v4 = 1'b0;
  endtask

  task automatic checkFrame4(input logic [7:0] b, input bit rd_end, input int push_k,
                             input logic [7:0] push_b);
    for (int k = 0; k < 10 * CPB4; k++) begin
      @(negedge clk);
      if (k == push_k) begin
        push_d4 = push_b;
        push_v4 = 1'b1;
      end else begin
        push_v4 = 1'b0;
      end
      checkBit($sformatf("tx4 byte %0h cyc %0d", b, k), tx4, frameBit(b, k));
      checkBit($sformatf("busy4 byte %0h cyc %0d", b, k), busy4, 1'b1);
      checkBit($sformatf("rd4 byte %0h cyc %0d", b, k), rd4, rd_end && (k == 10 * CPB4 - 1));
    end
  endtask

  task automatic checkIdle4(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkBit({tag, " tx4"}, tx4, 1'b1);
      checkBit({tag, " busy4"}, busy4, 1'b0);
      checkBit({tag, " rd4"}, rd4, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] sent[$];
    logic [7:0] b;
    int gap;
    int waited;

    rst     = 1'b1;
    push_v4 = 1'b0;
    push_d4 = 8'h00;
    push_vr = 1'b0;
    push_dr = 8'h00;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkBit("reset tx4", tx4, 1'b1);
      checkBit("reset busy4", busy4, 1'b0);
      checkBit("reset rd4", rd4, 1'b0);
      checkBit("reset tx2", tx2, 1'b1);
      checkBit("reset tx7", tx7, 1'b1);
    end
    rst = 1'b0;
    checkIdle4("post-reset", 5);

    $display("[TB] single byte");
    applyStimulus(8'hA5);
    checkBit("pop A5", rd4, 1'b1);
    checkFrame4(8'hA5, 1'b0, -1, 8'h00);
    checkIdle4("after A5", 4);

    $display("[TB] back-to-back");
    @(negedge clk);
    push_d4 = 8'h00;
    push_v4 = 1'b1;
    @(negedge clk);
    push_d4 = 8'hFF;
    checkBit("pop 00", rd4, 1'b1);
    checkFrame4(8'h00, 1'b1, -1, 8'h00);
    checkFrame4(8'hFF, 1'b0, -1, 8'h00);
    checkIdle4("after FF", 4);

    $display("[TB] late arrival");
    applyStimulus(8'h81);
    checkBit("pop 81", rd4, 1'b1);
    checkFrame4(8'h81, 1'b1, 12, 8'h3C);
    checkFrame4(8'h3C, 1'b0, -1, 8'h00);
    checkIdle4("after 3C", 4);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h5A);
    checkBit("pop 5A", rd4, 1'b1);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      checkBit($sformatf("partial tx4 cyc %0d", k), tx4, frameBit(8'h5A, k));
    end
    rst = 1'b1;
    @(negedge clk);
    checkBit("abort tx4", tx4, 1'b1);
    checkBit("abort busy4", busy4, 1'b0);
    checkBit("abort rd4", rd4, 1'b0);
    rst = 1'b0;
    checkIdle4("after abort", 30);

    $display("[TB] byte waiting through reset");
    @(negedge clk);
    rst     = 1'b1;
    push_d4 = 8'h6B;
    push_v4 = 1'b1;
    @(negedge clk);
    push_v4 = 1'b0;
    checkBit("rd4 held in reset 1", rd4, 1'b0);
    @(negedge clk);
    checkBit("rd4 held in reset 2", rd4, 1'b0);
    rst = 1'b0;
    #1;
    checkBit("rd4 first cycle after reset", rd4, 1'b1);
    checkFrame4(8'h6B, 1'b0, -1, 8'h00);
    checkIdle4("after 6B", 4);

    $display("[TB] random scoreboard");
    for (int i = 0; i < NRAND; i++) begin
      b = 8'($urandom_range(0, 255));
      sent.push_back(b);
      @(negedge clk);
      push_dr = b;
      push_vr = 1'b1;
      @(negedge clk);
      push_vr = 1'b0;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : 0;
      repeat (gap) @(negedge clk);
    end

    waited = 0;
    while ((dec2.size() < NRAND || dec7.size() < NRAND) && waited < 40000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("decoded count cpb2", 32'(dec2.size()), 32'(NRAND));
    checkOutput("decoded count cpb7", 32'(dec7.size()), 32'(NRAND));
    for (int i = 0; i < NRAND; i++) begin
      checkOutput($sformatf("byte cpb2 #%0d", i),
                  (i < dec2.size()) ? 32'(dec2[i]) : 32'hFFFF_FFFF, 32'(sent[i]));
      checkOutput($sformatf("byte cpb7 #%0d", i),
                  (i < dec7.size()) ? 32'(dec7[i]) : 32'hFFFF_FFFF, 32'(sent[i]));
    end
    checkOutput("framing errors cpb2", 32'(ferr2), 32'd0);
    checkOutput("framing errors cpb7", 32'(ferr7), 32'd0);
    checkOutput("pop while empty or in reset", 32'(viol), 32'd0);
    checkBit("final idle tx2", tx2, 1'b1);
    checkBit("final idle tx7", tx7, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
